tf_stage_provider: RTL and testbench

//  Streams twiddle factors W_N^k for one radix-2 DIF FFT stage, chosen per run, replacing the fixed linear-sweep twiddle provider.

---
 rtl/tf_stage_provider.sv | 166 ++++++++++++++++
 tb/tb_tf_stage_provider.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tf_stage_provider.sv
// tf_stage_provider: streams the twiddle factors of one radix-2 DIF FFT stage.
// A per-run stage index selects the ROM address law rom_addr = (b mod (N>>(s+1))) << s.
// The external ROM has one cycle of read latency. Each returned word is optionally
// conjugated and pushed into a 2-entry FIFO. The FIFO drives a valid/ready stream
// that carries the butterfly index and a last flag.
module tf_stage_provider #(
    parameter int FLOAT_LEN   = 32,
    parameter int LOG2N       = 13,
    parameter int TF_ADDR_LEN = 12,
    parameter int STAGE_W     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [STAGE_W-1:0]     stage,
    input  logic                   inverse,
    output logic                   busy,
    output logic                   err,
    output logic                   rom_en,
    output logic [TF_ADDR_LEN-1:0] rom_addr,
    input  logic [2*FLOAT_LEN-1:0] rom_data,
    output logic [2*FLOAT_LEN-1:0] tf_data,
    output logic [LOG2N-2:0]       tf_idx,
    output logic                   tf_last,
    output logic                   tf_valid,
    input  logic                   tf_ready
);
    localparam int WORD_W = 2 * FLOAT_LEN;
    localparam int IDX_W  = LOG2N - 1;
    localparam logic [IDX_W-1:0]       LAST_B    = {IDX_W{1'b1}};
    localparam logic [STAGE_W-1:0]     STAGE_LIM = STAGE_W'(LOG2N);
    localparam logic [IDX_W-1:0]       B_ONE     = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [TF_ADDR_LEN-1:0] J_ONE     = {{(TF_ADDR_LEN-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Conjugate {re,im} by flipping the sign bit of the imaginary half.
    function automatic logic [WORD_W-1:0] conj_word(input logic [WORD_W-1:0] w, input logic inv);
        logic [WORD_W-1:0] r;
        r = w;
        r[FLOAT_LEN-1] = w[FLOAT_LEN-1] ^ inv;
        return r;
    endfunction

    state_t                 state_r, state_s;
    logic                   inv_r;
    logic [STAGE_W-1:0]     stage_r;
    logic [TF_ADDR_LEN-1:0] jmax_r, j_r, rom_addr_r, j_inc_s;
    logic [IDX_W-1:0]       b_r;
    logic                   err_r;
    logic                   pend_r, pend_last_r;
    logic [IDX_W-1:0]       pend_idx_r;
    logic [WORD_W-1:0]      fifo_data_r [0:1];
    logic [IDX_W-1:0]       fifo_idx_r  [0:1];
    logic                   fifo_last_r [0:1];
    logic                   wr_ptr_r, rd_ptr_r;
    logic [1:0]             cnt_r, occ_s;
    logic                   start_ok_s, pop_s, rom_en_s;

    assign start_ok_s = start & (state_r == ST_IDLE) & (stage < STAGE_LIM);
    assign pop_s      = (cnt_r != 2'd0) & tf_ready;
    // Occupancy counts this cycle's pop, so a single read in flight plus one
    // queued word still lets a new read issue. This sustains one factor per cycle.
    assign occ_s      = cnt_r + {1'b0, pend_r} - {1'b0, pop_s};
    assign j_inc_s    = j_r + J_ONE;

    // Next-state and read-issue decision.
    always_comb begin
        state_s  = state_r;
        rom_en_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) state_s = ST_RUN;
                else            state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (occ_s < 2'd2) begin
                    rom_en_s = 1'b1;
                    if (b_r == LAST_B) state_s = ST_DRAIN;
                    else               state_s = ST_RUN;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (pop_s & fifo_last_r[rd_ptr_r]) state_s = ST_IDLE;
                else                               state_s = ST_DRAIN;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_s;
    end

    // Run parameters, address counters, the in-flight read tag, the FIFO and the error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inv_r       <= 1'b0;
            stage_r     <= {STAGE_W{1'b0}};
            jmax_r      <= {TF_ADDR_LEN{1'b0}};
            j_r         <= {TF_ADDR_LEN{1'b0}};
            rom_addr_r  <= {TF_ADDR_LEN{1'b0}};
            b_r         <= {IDX_W{1'b0}};
            err_r       <= 1'b0;
            pend_r      <= 1'b0;
            pend_idx_r  <= {IDX_W{1'b0}};
            pend_last_r <= 1'b0;
            wr_ptr_r    <= 1'b0;
            rd_ptr_r    <= 1'b0;
            cnt_r       <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_data_r[i] <= {WORD_W{1'b0}};
                fifo_idx_r[i]  <= {IDX_W{1'b0}};
                fifo_last_r[i] <= 1'b0;
            end
        end else begin
            err_r <= start & ~start_ok_s;
            if (start_ok_s) begin
                inv_r      <= inverse;
                stage_r    <= stage;
                jmax_r     <= {TF_ADDR_LEN{1'b1}} >> stage;
                j_r        <= {TF_ADDR_LEN{1'b0}};
                rom_addr_r <= {TF_ADDR_LEN{1'b0}};
                b_r        <= {IDX_W{1'b0}};
            end else if (rom_en_s) begin
                b_r <= b_r + B_ONE;
                if (j_r == jmax_r) begin
                    j_r        <= {TF_ADDR_LEN{1'b0}};
                    rom_addr_r <= {TF_ADDR_LEN{1'b0}};
                end else begin
                    j_r        <= j_inc_s;
                    rom_addr_r <= j_inc_s << stage_r;
                end
            end
            pend_r      <= rom_en_s;
            pend_idx_r  <= b_r;
            pend_last_r <= (b_r == LAST_B);
            if (pend_r) begin
                fifo_data_r[wr_ptr_r] <= conj_word(rom_data, inv_r);
                fifo_idx_r[wr_ptr_r]  <= pend_idx_r;
                fifo_last_r[wr_ptr_r] <= pend_last_r;
                wr_ptr_r              <= ~wr_ptr_r;
            end
            if (pop_s) rd_ptr_r <= ~rd_ptr_r;
            cnt_r <= cnt_r + {1'b0, pend_r} - {1'b0, pop_s};
        end
    end

    assign busy     = (state_r != ST_IDLE);
    assign err      = err_r;
    assign rom_en   = rom_en_s;
    assign rom_addr = rom_addr_r;
    assign tf_valid = (cnt_r != 2'd0);
    assign tf_data  = fifo_data_r[rd_ptr_r];
    assign tf_idx   = fifo_idx_r[rd_ptr_r];
    assign tf_last  = fifo_last_r[rd_ptr_r];

endmodule

// File: tb/tb_tf_stage_provider.sv
// Directed testbench for tf_stage_provider (N=8192, one stage per run).
module tb_tf_stage_provider;
    logic        clk = 1'b0;
    logic        rst, start, inverse, tf_ready;
    logic [3:0]  stage;
    logic        busy, err, rom_en, tf_last, tf_valid;
    logic [11:0] rom_addr, tf_idx;
    logic [63:0] rom_data = 64'd0;
    logic [63:0] tf_data;
    logic        rom_special = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [11:0] obs_addr [0:4095];
    logic [63:0] obs_data [0:4095];
    logic [11:0] obs_idx  [0:4095];
    logic        obs_last [0:4095];
    int   n_issue, n_out, first_valid, done_cyc, stall_bad, err_cnt;
    logic timed_out;

    tf_stage_provider dut (
        .clk(clk), .rst(rst), .start(start), .stage(stage), .inverse(inverse),
        .busy(busy), .err(err), .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .tf_data(tf_data), .tf_idx(tf_idx), .tf_last(tf_last), .tf_valid(tf_valid),
        .tf_ready(tf_ready)
    );

    always #5 clk = ~clk;

    // ROM contents: the real part tags the address. The imaginary sign bit is addr[0].
    function automatic logic [63:0] rom_word(input logic [11:0] a, input logic special);
        logic [31:0] re, im;
        re = {20'h3F800, a};
        im = {a[0], 7'h12, 12'h000, a};
        if (special) return 64'h3F800000_BF800000;
        else         return {re, im};
    endfunction

    // Expected factor for butterfly k at stage s.
    function automatic logic [63:0] exp_word(input int k, input int s, input logic inv, input logic special);
        int a;
        logic [63:0] w;
        a = (k % (4096 >> s)) << s;
        w = rom_word(12'(a), special);
        if (inv) w[31] = ~w[31];
        return w;
    endfunction

    // External ROM with one cycle of read latency.
    always @(posedge clk) begin
        if (rom_en) rom_data <= rom_word(rom_addr, rom_special);
    end

    // Start one run at the current negedge and record what the DUT does until busy falls.
    // The task returns at the negedge where busy is first seen low.
    task automatic run_stream(input int s, input logic inv, input int rdy_pct, input int extra_start_cyc);
        int cyc;
        logic done, stall_prev, pl;
        logic [63:0] pd;
        logic [11:0] pi;
        n_issue = 0; n_out = 0; first_valid = -1; done_cyc = -1; stall_bad = 0; err_cnt = 0;
        cyc = 0; done = 1'b0; stall_prev = 1'b0; pd = 64'd0; pi = 12'd0; pl = 1'b0;
        stage = 4'(s); inverse = inv; start = 1'b1;
        @(negedge clk);
        start = 1'b0; stage = 4'(s ^ 5); inverse = ~inv;
        while (!done && cyc < 12000) begin
            tf_ready = (int'($urandom_range(99)) < rdy_pct);
            #1;
            if (err) err_cnt++;
            if (tf_valid && first_valid < 0) first_valid = cyc;
            if (stall_prev && (!tf_valid || tf_data !== pd || tf_idx !== pi || tf_last !== pl)) stall_bad++;
            stall_prev = tf_valid && !tf_ready;
            pd = tf_data; pi = tf_idx; pl = tf_last;
            if (rom_en) begin
                if (n_issue < 4096) obs_addr[n_issue] = rom_addr;
                n_issue++;
            end
            if (tf_valid && tf_ready) begin
                if (n_out < 4096) begin
                    obs_data[n_out] = tf_data;
                    obs_idx[n_out]  = tf_idx;
                    obs_last[n_out] = tf_last;
                end
                n_out++;
            end
            start = (cyc == extra_start_cyc);
            if (start) stage = 4'd3;
            if (!busy) begin
                done = 1'b1;
                done_cyc = cyc;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        tf_ready = 1'b1;
        timed_out = !done;
    endtask

    task automatic test_reset();
        logic [92:0] snap;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        snap = {busy, err, rom_en, tf_valid, tf_last, rom_addr, tf_idx, tf_data};
        checks++;
        if (snap !== 93'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", snap);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_addr_law();
        int st_list[3] = '{0, 3, 12};
        int s, bad_a, bad_d;
        for (int t = 0; t < 3; t++) begin
            s = st_list[t];
            run_stream(s, 1'b0, 100, -1);
            checks++;
            if (timed_out || n_issue !== 4096) begin
                errors++;
                $display("FAIL issue_count s=%0d got %0d want 4096 (timeout=%0b)", s, n_issue, timed_out);
            end
            checks++;
            if (n_out !== 4096) begin
                errors++;
                $display("FAIL transfer_count s=%0d got %0d want 4096", s, n_out);
            end
            bad_a = 0; bad_d = 0;
            for (int k = 0; k < 4096; k++) begin
                if (obs_addr[k] !== 12'((k % (4096 >> s)) << s)) bad_a++;
                if (obs_data[k] !== exp_word(k, s, 1'b0, 1'b0) || obs_idx[k] !== 12'(k)
                    || obs_last[k] !== (k == 4095)) bad_d++;
            end
            checks++;
            if (bad_a !== 0) begin
                errors++;
                $display("FAIL addr_seq s=%0d got %0d bad addresses want 0 (addr[1]=%0d)", s, bad_a, obs_addr[1]);
            end
            checks++;
            if (bad_d !== 0) begin
                errors++;
                $display("FAIL data_seq s=%0d got %0d bad transfers want 0", s, bad_d);
            end
            checks++;
            if (first_valid !== 2) begin
                errors++;
                $display("FAIL latency s=%0d got %0d want 2", s, first_valid);
            end
            checks++;
            if (done_cyc !== 4098) begin
                errors++;
                $display("FAIL busy_fall s=%0d got %0d want 4098", s, done_cyc);
            end
        end
    endtask

    task automatic test_inverse();
        int bad;
        rom_special = 1'b1;
        run_stream(12, 1'b1, 100, -1);
        rom_special = 1'b0;
        checks++;
        if (obs_data[0] !== 64'h3F800000_3F800000) begin
            errors++;
            $display("FAIL conj_first got %h want 3f8000003f800000", obs_data[0]);
        end
        bad = 0;
        for (int k = 0; k < 4096; k++)
            if (obs_data[k] !== 64'h3F800000_3F800000) bad++;
        checks++;
        if (bad !== 0 || n_out !== 4096) begin
            errors++;
            $display("FAIL conj_all got %0d bad of %0d want 0 of 4096", bad, n_out);
        end
    endtask

    task automatic test_random_ready();
        int bad;
        run_stream(0, 1'b1, 50, -1);
        checks++;
        if (timed_out || n_out !== 4096 || n_issue !== 4096) begin
            errors++;
            $display("FAIL rand_counts got out=%0d issue=%0d want 4096/4096", n_out, n_issue);
        end
        bad = 0;
        for (int k = 0; k < 4096; k++)
            if (obs_data[k] !== exp_word(k, 0, 1'b1, 1'b0) || obs_idx[k] !== 12'(k)
                || obs_last[k] !== (k == 4095)) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL rand_seq got %0d bad transfers want 0", bad);
        end
        checks++;
        if (stall_bad !== 0) begin
            errors++;
            $display("FAIL stall_hold got %0d unstable stalls want 0", stall_bad);
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        run_stream(12, 1'b0, 100, -1);
        run_stream(1, 1'b0, 100, -1);
        checks++;
        if (first_valid !== 2 || done_cyc !== 4098) begin
            errors++;
            $display("FAIL b2b_timing got first=%0d done=%0d want 2/4098", first_valid, done_cyc);
        end
        bad = 0;
        for (int k = 0; k < 4096; k++)
            if (obs_data[k] !== exp_word(k, 1, 1'b0, 1'b0) || obs_idx[k] !== 12'(k)) bad++;
        checks++;
        if (bad !== 0 || n_out !== 4096) begin
            errors++;
            $display("FAIL b2b_seq got %0d bad of %0d want 0 of 4096", bad, n_out);
        end
    endtask

    task automatic test_err();
        int bad;
        stage = 4'd13; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL err_bad_stage got err=%b busy=%b want 1/0", err, busy);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || busy !== 1'b0 || rom_en !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse_end got err=%b busy=%b rom_en=%b want 0/0/0", err, busy, rom_en);
        end
        run_stream(12, 1'b0, 100, 50);
        checks++;
        if (err_cnt !== 1) begin
            errors++;
            $display("FAIL err_busy_start got %0d err cycles want 1", err_cnt);
        end
        bad = 0;
        for (int k = 0; k < 4096; k++)
            if (obs_data[k] !== exp_word(k, 12, 1'b0, 1'b0)) bad++;
        checks++;
        if (bad !== 0 || n_out !== 4096 || done_cyc !== 4098) begin
            errors++;
            $display("FAIL err_run_intact got bad=%0d out=%0d done=%0d want 0/4096/4098", bad, n_out, done_cyc);
        end
    endtask

    task automatic test_midrun_reset();
        int cyc;
        logic [92:0] snap;
        stage = 4'd0; inverse = 1'b0; tf_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (cyc < 500 && !(rom_en === 1'b1 && rom_addr === 12'd100)) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc >= 500 || tf_idx !== 12'd98) begin
            errors++;
            $display("FAIL midrun_reach got cyc=%0d idx=%0d want <500/98", cyc, tf_idx);
        end
        rst = 1'b1;
        #2;
        snap = {busy, err, rom_en, tf_valid, tf_last, rom_addr, tf_idx, tf_data};
        checks++;
        if (snap !== 93'd0) begin
            errors++;
            $display("FAIL midrun_reset_outputs got %h want 0", snap);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (rom_en !== 1'b1 || rom_addr !== 12'd0) begin
            errors++;
            $display("FAIL restart_addr got rom_en=%b addr=%0d want 1/0", rom_en, rom_addr);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (tf_valid !== 1'b1 || tf_idx !== 12'd0 || tf_data !== rom_word(12'd0, 1'b0)) begin
            errors++;
            $display("FAIL restart_first got valid=%b idx=%0d data=%h want 1/0/%h",
                     tf_valid, tf_idx, tf_data, rom_word(12'd0, 1'b0));
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stage = 4'd0; inverse = 1'b0; tf_ready = 1'b1;
        test_reset();
        test_addr_law();
        test_inverse();
        test_random_ready();
        test_back_to_back();
        test_err();
        test_midrun_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
